// File: rtl/gpmc_regbank_arbiter.sv
// gpmc_regbank_arbiter
// Shares one single-port register bank between the GPMC host bridge and a set
// of local FPGA requesters. The host has priority, but after MAX_HOST_RUN
// back-to-back host grants with local work pending one local requester is
// served. Local requesters are served round-robin. Each access takes
// IDLE -> ISSUE -> DONE, so at most one access is completed every 3 cycles.
module gpmc_regbank_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_HOST_RUN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [ADDR_WIDTH-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0]         host_wdata,
    output logic                          host_ack,
    output logic [DATA_WIDTH-1:0]         host_rdata,
    input  logic [NUM_REQ-1:0]            loc_req,
    input  logic [NUM_REQ-1:0]            loc_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] loc_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] loc_wdata,
    output logic [NUM_REQ-1:0]            loc_ack,
    output logic [DATA_WIDTH-1:0]         loc_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy,
    output logic [3:0]                    grant_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RUN_W = $clog2(MAX_HOST_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_HOST_RUN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [3:0] HOST_ID = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Round-robin search: first requesting index at or above ptr, wrapping
    // modulo NUM_REQ. Returns {found, index}. Scanning from the farthest
    // candidate down lets the nearest one overwrite the result last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] pick;
        int             cand;
        pick = {(IDX_W + 1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick = {1'b1, cand[IDX_W-1:0]};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Pointer successor with wrap for any NUM_REQ, including non-powers of two.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        if (idx == IDX_LAST) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    // One-hot decode of a local requester index.
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = (idx == IDX_W'(i));
        end
        return vec;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [RUN_W-1:0]        host_run_r;
    logic                    grant_host_r;
    logic [IDX_W-1:0]        grant_idx_r;
    logic                    mem_en_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic                    host_ack_r;
    logic [NUM_REQ-1:0]      loc_ack_r;
    logic [DATA_WIDTH-1:0]   host_rdata_r;
    logic [DATA_WIDTH-1:0]   loc_rdata_r;
    logic                    busy_r;
    logic [3:0]              grant_id_r;

    logic                    loc_any_s;
    logic [IDX_W:0]          rr_pick_s;
    logic                    rr_found_s;
    logic [IDX_W-1:0]        rr_idx_s;
    logic                    host_win_s;
    logic                    loc_win_s;
    logic                    grant_s;
    logic                    loc_we_sel_s;
    logic [ADDR_WIDTH-1:0]   loc_addr_sel_s;
    logic [DATA_WIDTH-1:0]   loc_wdata_sel_s;
    logic                    rd_done_s;

    // Arbitration decision from the requests seen this cycle (used only in IDLE).
    always_comb begin
        loc_any_s  = |loc_req;
        rr_pick_s  = rr_pick(loc_req, rr_ptr_r);
        rr_found_s = rr_pick_s[IDX_W];
        rr_idx_s   = rr_pick_s[IDX_W-1:0];
        if (host_req && !((host_run_r == RUN_MAX) && loc_any_s)) begin
            host_win_s = 1'b1;
            loc_win_s  = 1'b0;
        end else begin
            host_win_s = 1'b0;
            loc_win_s  = rr_found_s;
        end
        grant_s = host_win_s || loc_win_s;
    end

    // Command fields of the round-robin winner, unpacked from the flat buses.
    always_comb begin
        loc_we_sel_s    = loc_we[rr_idx_s];
        loc_addr_sel_s  = loc_addr[int'(rr_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
        loc_wdata_sel_s = loc_wdata[int'(rr_idx_s) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state logic of the IDLE -> ISSUE -> DONE access sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the winner's command at grant and strobe the bank in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            grant_host_r <= 1'b0;
            grant_idx_r  <= {IDX_W{1'b0}};
            grant_id_r   <= 4'd0;
        end else begin
            mem_en_r <= (state_r == ST_IDLE) && grant_s;
            if ((state_r == ST_IDLE) && grant_s) begin
                if (host_win_s) begin
                    grant_host_r <= 1'b1;
                    mem_we_r     <= host_we;
                    mem_addr_r   <= host_addr;
                    mem_wdata_r  <= host_wdata;
                    grant_id_r   <= HOST_ID;
                end else begin
                    grant_host_r <= 1'b0;
                    grant_idx_r  <= rr_idx_s;
                    mem_we_r     <= loc_we_sel_s;
                    mem_addr_r   <= loc_addr_sel_s;
                    mem_wdata_r  <= loc_wdata_sel_s;
                    grant_id_r   <= 4'(rr_idx_s);
                end
            end
        end
    end

    // Round-robin pointer and host run counter, updated on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r   <= {IDX_W{1'b0}};
            host_run_r <= {RUN_W{1'b0}};
        end else if ((state_r == ST_IDLE) && grant_s) begin
            if (host_win_s) begin
                if (!loc_any_s) begin
                    host_run_r <= {RUN_W{1'b0}};
                end else if (host_run_r != RUN_MAX) begin
                    host_run_r <= host_run_r + RUN_W'(1);
                end
            end else begin
                host_run_r <= {RUN_W{1'b0}};
                rr_ptr_r   <= idx_next(rr_idx_s);
            end
        end
    end

    // Completion pulses: exactly one ack bit during DONE, to the granted side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_ack_r <= 1'b0;
            loc_ack_r  <= {NUM_REQ{1'b0}};
        end else begin
            host_ack_r <= (state_r == ST_ISSUE) && grant_host_r;
            if ((state_r == ST_ISSUE) && !grant_host_r) begin
                loc_ack_r <= idx_onehot(grant_idx_r);
            end else begin
                loc_ack_r <= {NUM_REQ{1'b0}};
            end
        end
    end

    // Hold the last read data of each side once its DONE cycle ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata_r <= {DATA_WIDTH{1'b0}};
            loc_rdata_r  <= {DATA_WIDTH{1'b0}};
        end else if (rd_done_s) begin
            if (grant_host_r) begin
                host_rdata_r <= mem_rdata;
            end else begin
                loc_rdata_r <= mem_rdata;
            end
        end
    end

    // Busy flag tracks the state the FSM is entering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    // The bank returns read data during DONE, the same cycle as the ack, so
    // the granted side sees mem_rdata directly then and the held copy after.
    assign rd_done_s  = (state_r == ST_DONE) && !mem_we_r;
    assign host_rdata = (rd_done_s && grant_host_r)  ? mem_rdata : host_rdata_r;
    assign loc_rdata  = (rd_done_s && !grant_host_r) ? mem_rdata : loc_rdata_r;

    assign host_ack  = host_ack_r;
    assign loc_ack   = loc_ack_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

endmodule

// File: doc/gpmc_regbank_arbiter.md
Name: gpmc_regbank_arbiter

Overview:
- Shares one 16-entry x 16-bit register bank between the GPMC host bridge and NUM_REQ local FPGA requesters (LED/PMOD drivers, status logic).
- The host has priority, bounded by a starvation limit. Local requesters are served round-robin.
- Drives the bank through a single-port interface with 1-cycle read latency.
- Sits between the GPMC bridge front end and the register storage.

Parameters:
- NUM_REQ, 4: number of local requesters (1..8).
- ADDR_WIDTH, 4: register address width.
- DATA_WIDTH, 16: register data width.
- MAX_HOST_RUN, 4: maximum consecutive host grants while any local request is pending.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_req  in  1  host access request; level, held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host register address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_WIDTH  host read data; valid with host_ack on reads.
- loc_req  in  NUM_REQ  per-requester request; level, held until the matching loc_ack bit.
- loc_we  in  NUM_REQ  per-requester write enable.
- loc_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- loc_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- loc_ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- loc_rdata  out  DATA_WIDTH  shared local read data; valid with loc_ack on reads.
- mem_en  out  1  bank access strobe.
- mem_we  out  1  bank write enable, qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  bank address.
- mem_wdata  out  DATA_WIDTH  bank write data.
- mem_rdata  in  DATA_WIDTH  bank read data; valid the cycle after mem_en.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  4  current or last grant: 0..NUM_REQ-1 = local requester, 15 = host.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All ack bits, mem_en, mem_we and busy = 0.
  - host_rdata, loc_rdata, mem_addr, mem_wdata = 0.
  - grant_id = 0, round-robin pointer = 0, host run counter = 0.
  - An in-flight access is aborted with no ack.
- FSM states: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE: arbitrate among the current requests. If none, stay in IDLE. Otherwise latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set grant_id, and go to ISSUE.
- ISSUE: mem_en = 1 for exactly this cycle; go to DONE.
- DONE:
  - Reads: capture mem_rdata into host_rdata or loc_rdata (the granted side only).
  - Pulse the winner's ack for this cycle; go to IDLE.
  - Writes leave both rdata registers unchanged.
- Latency and throughput:
  - Request sampled high in IDLE at edge t: mem_en is high in cycle t+1, ack and rdata in cycle t+2.
  - One access per 3 cycles maximum.
- Arbitration rules:
  - The host wins whenever host_req = 1, unless the host run counter equals MAX_HOST_RUN and some loc_req bit is set; then a local requester wins.
  - Among local requesters, pick the first requesting index starting at the pointer and moving upward modulo NUM_REQ.
  - After a local grant i, the pointer becomes (i+1) mod NUM_REQ.
  - Host run counter: increments on a host grant, saturating at MAX_HOST_RUN. It clears on any local grant, and also when a host grant occurs with no local request pending.
- Handshake rules:
  - Command inputs are latched only at grant; changing them afterwards has no effect.
  - A request deasserted after grant still completes and acks.
  - A request still high in the cycle after its ack is a new request.
  - A requester must drop its req in the ack cycle to avoid a repeat access.
- Simultaneous events: a request arriving during ISSUE or DONE waits. Arbitration happens only in IDLE, using the values sampled there.
- Ack exclusivity: at most one ack bit (host_ack or any loc_ack bit) is high in any cycle.
- Width rules:
  - grant_id is zero-extended for local indices.
  - Pointer arithmetic wraps modulo NUM_REQ, including non-power-of-two values.

Test Plan:
- Reset, then host write addr 2 data 0xBEEF, then host read addr 2 -> mem_en high 1 cycle each; host_ack at t+2; read returns host_rdata = 0xBEEF.
- loc_req = 4'b1111 held, host idle -> grants in order 0,1,2,3,0; each loc_ack one-hot; 3-cycle spacing.
- host_req held high with loc_req[2] high -> 4 host grants, then loc_ack[2], then host again; grant_id sequence 15,15,15,15,2,15.
- Host and local 1 request in the same IDLE cycle, counter 0 -> host served first; local 1 acked 3 cycles later.
- rst asserted during ISSUE of a local read -> no ack; outputs return to reset values immediately; the following request is served normally from IDLE.
- Local 0 write 0x1234 with loc_req kept high after ack -> second write occurs; loc_rdata stays 0x0000; host_rdata is unchanged.
